// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-back bypass and a per-register
// busy scoreboard used by ID to detect RAW hazards.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_en,
  input  logic [NRD*$clog2(NREGS)-1:0] rs_sel,
  output logic [NRD*XLEN-1:0]     rs_data,
  output logic [NRD-1:0]          rs_busy,
  input  logic [NWR-1:0]          wb_en,
  input  logic [NWR*$clog2(NREGS)-1:0] wb_rd,
  input  logic [NWR*XLEN-1:0]     wb_data,
  input  logic                    iss_en,
  input  logic [$clog2(NREGS)-1:0] iss_rd,
  input  logic                    flush
);

  localparam int AW = $clog2(NREGS);
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             fwd_ok;

  // Forwarding is suppressed while reset is held so outputs stay zero.
  assign fwd_ok = BP && id_en && !reset;

  // Later ports overwrite earlier ones, giving the highest index priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (id_en) begin
      for (int i = 0; i < NWR; i++) begin
        if (wb_en[i] && !(ZR && wb_rd[i*AW +: AW] == '0))
          regs[wb_rd[i*AW +: AW]] <= wb_data[i*XLEN +: XLEN];
      end
    end
  end

  // Clears applied before the set so an issue wins over a retiring write.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wb_en[i]) busy_nxt[wb_rd[i*AW +: AW]] = 1'b0;
      end
      if (iss_en && !(ZR && iss_rd == '0)) busy_nxt[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else if (id_en) busy <= busy_nxt;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   sel;
    logic            hit;
    logic [XLEN-1:0] val;
    logic            is_zero;

    assign sel     = rs_sel[p*AW +: AW];
    assign is_zero = ZR && (sel == '0);

    always_comb begin
      hit = 1'b0;
      val = regs[sel];
      for (int i = 0; i < NWR; i++) begin
        if (fwd_ok && wb_en[i] && wb_rd[i*AW +: AW] == sel) begin
          hit = 1'b1;
          val = wb_data[i*XLEN +: XLEN];
        end
      end
    end

    assign rs_data[p*XLEN +: XLEN] = is_zero ? '0 : val;
    assign rs_busy[p]              = !is_zero && busy[sel] && !hit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: bypass, port priority, x0, scoreboard,
// flush, id_en freeze and mid-write reset.
module tb_reg_file_mp;

  logic        clk;
  logic        reset;
  logic        id_en;
  logic [9:0]  rs_sel;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic [1:0]  wb_en;
  logic [9:0]  wb_rd;
  logic [63:0] wb_data;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        flush;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  reg_file_mp dut (
    .clk     (clk),
    .reset   (reset),
    .id_en   (id_en),
    .rs_sel  (rs_sel),
    .rs_data (rs_data),
    .rs_busy (rs_busy),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .iss_en  (iss_en),
    .iss_rd  (iss_rd),
    .flush   (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rs_sel = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] en, input logic [4:0] r0, input logic [31:0] d0,
                    input logic [4:0] r1, input logic [31:0] d1);
    wb_en   = en;
    wb_rd   = {r1, r0};
    wb_data = {d1, d0};
  endtask

  // Inputs change on the falling edge; outputs sampled 1ns later.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; id_en = 1'b1; rs_sel = '0; flush = 1'b0;
    iss_en = 1'b0; iss_rd = '0;
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    nxt();
    wr(2'b01, 5'd5, 32'hEEEEFFFF, 5'd0, 32'h0);
    rd(5'd5, 5'd5);
    #1 chk("no_fwd_in_reset", rs_data, 64'h0);
    nxt();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    reset = 1'b0;

    // Test 1: everything zero and idle after reset
    for (int r = 0; r < 32; r++) begin
      rd(r[4:0], r[4:0]);
      #1;
      chk($sformatf("rst_data_r%0d", r), rs_data, 64'h0);
      chk($sformatf("rst_busy_r%0d", r), {62'h0, rs_busy}, 64'h0);
    end

    // Test 2: bypass then committed value
    nxt();
    wr(2'b01, 5'd5, 32'hEEEEFFFF, 5'd0, 32'h0);
    rd(5'd5, 5'd0);
    #1 chk("byp_r5", rs_data, {32'h0, 32'hEEEEFFFF});
    nxt();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1 chk("commit_r5", rs_data, {32'h0, 32'hEEEEFFFF});

    // Test 3: port priority on same address, x0 hardwired
    nxt();
    wr(2'b11, 5'd10, 32'h1, 5'd10, 32'h2);
    rd(5'd10, 5'd10);
    #1 chk("byp_prio_r10", rs_data, {32'h2, 32'h2});
    nxt();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1 chk("commit_prio_r10", rs_data, {32'h2, 32'h2});
    nxt();
    wr(2'b01, 5'd0, 32'hDEAD, 5'd0, 32'h0);
    rd(5'd0, 5'd0);
    #1 chk("x0_byp", rs_data, 64'h0);
    nxt();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1 chk("x0_commit", rs_data, 64'h0);

    // Test 4: issue marks busy, write clears with forwarding
    nxt();
    iss_en = 1'b1; iss_rd = 5'd7;
    rd(5'd7, 5'd7);
    #1 chk("busy_before_edge", {62'h0, rs_busy}, 64'h0);
    nxt();
    iss_en = 1'b0;
    #1 chk("busy_r7_set", {62'h0, rs_busy}, 64'h3);
    nxt();
    wr(2'b01, 5'd7, 32'd9, 5'd0, 32'h0);
    #1;
    chk("busy_r7_fwd", {62'h0, rs_busy}, 64'h0);
    chk("data_r7_fwd", rs_data, {32'd9, 32'd9});
    nxt();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("busy_r7_clr", {62'h0, rs_busy}, 64'h0);
    chk("data_r7", rs_data, {32'd9, 32'd9});

    // x0 is never busy
    nxt();
    iss_en = 1'b1; iss_rd = 5'd0;
    rd(5'd0, 5'd0);
    nxt();
    iss_en = 1'b0;
    #1 chk("x0_never_busy", {62'h0, rs_busy}, 64'h0);

    // Test 5: set beats same-cycle clear, then flush wins over issue
    nxt();
    iss_en = 1'b1; iss_rd = 5'd3;
    wr(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
    rd(5'd3, 5'd3);
    #1 chk("r3_busy_pre", {62'h0, rs_busy}, 64'h0);
    nxt();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    iss_rd = 5'd4;
    #1;
    chk("r3_busy_set_wins", {62'h0, rs_busy}, 64'h3);
    chk("r3_data", rs_data, {32'h33, 32'h33});
    nxt();
    iss_en = 1'b0;
    rd(5'd3, 5'd4);
    #1 chk("r3_r4_busy", {62'h0, rs_busy}, 64'h3);
    nxt();
    flush = 1'b1; iss_en = 1'b1; iss_rd = 5'd4;
    #1 chk("busy_during_flush", {62'h0, rs_busy}, 64'h3);
    nxt();
    flush = 1'b0; iss_en = 1'b0;
    #1 chk("busy_after_flush", {62'h0, rs_busy}, 64'h0);

    // Test 6: id_en low freezes everything and disables bypass
    nxt();
    id_en = 1'b0;
    wr(2'b11, 5'd12, 32'h55, 5'd13, 32'h77);
    iss_en = 1'b1; iss_rd = 5'd12;
    rd(5'd12, 5'd13);
    #1 chk("frz_no_byp", rs_data, 64'h0);
    nxt();
    id_en = 1'b1; iss_en = 1'b0;
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("frz_data", rs_data, 64'h0);
    chk("frz_busy", {62'h0, rs_busy}, 64'h0);

    // Reset asserted mid-write: nothing commits
    nxt();
    wr(2'b01, 5'd20, 32'h1234, 5'd0, 32'h0);
    iss_en = 1'b1; iss_rd = 5'd20;
    rd(5'd20, 5'd10);
    #1 chk("pre_rst_byp", rs_data, {32'h2, 32'h1234});
    reset = 1'b1;
    #1 chk("rst_kills_byp", rs_data, 64'h0);
    nxt();
    reset = 1'b0; iss_en = 1'b0;
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("post_rst_data", rs_data, 64'h0);
    chk("post_rst_busy", {62'h0, rs_busy}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
